// File: rtl/wm_pkg.sv
// -----------------------------------------------------------------------------
// wm_pkg -- shared washing-machine definitions.
// Holds the controller state codes and the default duration of each timed
// phase (in timer ticks). Used by the controller and by phase_timer.
// No ports (package).
// -----------------------------------------------------------------------------
package wm_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL_WATER = 3'd2,
    HEAT_WATER = 3'd3,
    WASH       = 3'd4,
    RINSE      = 3'd5,
    SPIN       = 3'd6
  } wm_state_e;

  localparam int FILL_TIME_DEF  = 32'sd2;
  localparam int HEAT_TIME_DEF  = 32'sd3;
  localparam int WASH_TIME_DEF  = 32'sd5;
  localparam int RINSE_TIME_DEF = 32'sd3;
  localparam int SPIN_TIME_DEF  = 32'sd3;

  // True for the state codes that have a phase duration attached.
  function automatic logic is_timed(input logic [2:0] code);
    case (code)
      FILL_WATER, HEAT_WATER, WASH, RINSE, SPIN: is_timed = 1'b1;
      default:                                   is_timed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer_if.sv
// -----------------------------------------------------------------------------
// phase_timer_if -- controller <-> phase timer signal bundle.
//   state, pause        : controller -> timer (current state code, freeze)
//   sig_Full, sig_Temperature, sig_Completed : phase-target level flags
//   phase_Done          : one-cycle pulse when any level flag rises
//   remaining_Time      : ticks left in the current timed phase
//   total_Ticks         : ticks since leaving an untimed state (saturating)
// master = controller side, slave = timer side.
// -----------------------------------------------------------------------------
interface phase_timer_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       state;
  logic             pause;
  logic             sig_Full;
  logic             sig_Temperature;
  logic             sig_Completed;
  logic             phase_Done;
  logic [CNT_W-1:0] remaining_Time;
  logic [15:0]      total_Ticks;

  modport master (
    output state, pause,
    input  sig_Full, sig_Temperature, sig_Completed, phase_Done,
    input  remaining_Time, total_Ticks
  );

  modport slave (
    input  state, pause,
    output sig_Full, sig_Temperature, sig_Completed, phase_Done,
    output remaining_Time, total_Ticks
  );
endinterface

// File: rtl/phase_timer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler -- divides the clock into timer ticks.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset
//   clear   : synchronous restart of the divider (takes priority over enable)
//   enable  : advance the divider this cycle
//   tick    : high in the enabled cycle where the divider is at PRESCALE-1
// With PRESCALE=1 every enabled cycle is a tick.
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int         LAST_I = PRESCALE - 32'sd1;
  localparam logic [7:0] LAST   = 8'(LAST_I);

  logic [7:0] presc_q;
  logic [7:0] presc_d;

  // Divider next value and tick decode.
  always_comb begin
    tick    = 1'b0;
    presc_d = presc_q;
    if (clear) begin
      presc_d = 8'd0;
    end else if (enable) begin
      if (presc_q == LAST) begin
        tick    = 1'b1;
        presc_d = 8'd0;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Divider register.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer -- times the washing-machine phases.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : phase_timer_if.slave (state/pause in; flags, phase_Done,
//           remaining_Time, total_Ticks out -- all registered)
// A change of state code restarts the phase. While the state is held, timed
// and not paused, each prescaler tick advances the phase counter up to the
// phase target; reaching it sets the flag belonging to that phase.
// -----------------------------------------------------------------------------
module phase_timer
  import wm_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PRESCALE   = 1,
  parameter int FILL_TIME  = FILL_TIME_DEF,
  parameter int HEAT_TIME  = HEAT_TIME_DEF,
  parameter int WASH_TIME  = WASH_TIME_DEF,
  parameter int RINSE_TIME = RINSE_TIME_DEF,
  parameter int SPIN_TIME  = SPIN_TIME_DEF
) (
  input logic         clock,
  input logic         reset,
  phase_timer_if.slave bus
);

  localparam longint DUR_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

  function automatic bit dur_ok(input int d);
    dur_ok = (d >= 32'sd1) && (longint'(d) <= DUR_MAX);
  endfunction

  localparam bit CFG_OK = (PRESCALE >= 32'sd1) && (PRESCALE <= 32'sd255) &&
                          dur_ok(FILL_TIME) && dur_ok(HEAT_TIME) &&
                          dur_ok(WASH_TIME) && dur_ok(RINSE_TIME) &&
                          dur_ok(SPIN_TIME);

  if (!CFG_OK) begin : g_bad_cfg
    $error("phase_timer: PRESCALE or a phase duration is out of range");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FILL_T  = CNT_W'(FILL_TIME);
  localparam logic [CNT_W-1:0] HEAT_T  = CNT_W'(HEAT_TIME);
  localparam logic [CNT_W-1:0] WASH_T  = CNT_W'(WASH_TIME);
  localparam logic [CNT_W-1:0] RINSE_T = CNT_W'(RINSE_TIME);
  localparam logic [CNT_W-1:0] SPIN_T  = CNT_W'(SPIN_TIME);

  function automatic logic [CNT_W-1:0] target_of(input logic [2:0] code);
    case (code)
      FILL_WATER: target_of = FILL_T;
      HEAT_WATER: target_of = HEAT_T;
      WASH:       target_of = WASH_T;
      RINSE:      target_of = RINSE_T;
      SPIN:       target_of = SPIN_T;
      default:    target_of = '0;
    endcase
  endfunction

  logic [2:0]       prev_state_q, prev_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [15:0]      total_q, total_d;
  logic             full_q, full_d;
  logic             temp_q, temp_d;
  logic             comp_q, comp_d;
  logic             done_q, done_d;

  logic             changed_s;
  logic             timed_s;
  logic [CNT_W-1:0] target_s;
  logic             presc_en_s;
  logic             tick_s;
  logic             hit_s;

  always_comb begin
    changed_s  = (bus.state != prev_state_q);
    timed_s    = is_timed(bus.state);
    target_s   = target_of(bus.state);
    // A state change owns the cycle: the divider is cleared, not advanced.
    presc_en_s = !changed_s && timed_s && !bus.pause;
  end

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (changed_s),
    .enable (presc_en_s),
    .tick   (tick_s)
  );

  // Phase counter, flags, done pulse and tick totals.
  always_comb begin
    prev_state_d = bus.state;
    cnt_d        = cnt_q;
    full_d       = full_q;
    temp_d       = temp_q;
    comp_d       = comp_q;
    total_d      = total_q;
    hit_s        = tick_s && (cnt_q < target_s) && ((cnt_q + CNT_ONE) == target_s);

    if (changed_s) begin
      cnt_d  = '0;
      full_d = 1'b0;
      temp_d = 1'b0;
      comp_d = 1'b0;
    end else if (tick_s && (cnt_q < target_s)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    if (hit_s) begin
      case (bus.state)
        FILL_WATER:        full_d = 1'b1;
        HEAT_WATER:        temp_d = 1'b1;
        WASH, RINSE, SPIN: comp_d = 1'b1;
        default:           full_d = full_q;
      endcase
    end else begin
      full_d = full_d;
    end

    if (!timed_s) begin
      total_d = 16'd0;
    end else if (tick_s && (total_q != 16'hFFFF)) begin
      total_d = total_q + 16'd1;
    end else begin
      total_d = total_q;
    end

    // Registered against the counter value being loaded, so it reads 0
    // in the same cycle the flag appears.
    if (timed_s) begin
      remaining_d = target_s - cnt_d;
    end else begin
      remaining_d = '0;
    end

    done_d = (full_d & ~full_q) | (temp_d & ~temp_q) | (comp_d & ~comp_q);
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_state_q <= 3'd0;
      cnt_q        <= '0;
      remaining_q  <= '0;
      total_q      <= 16'd0;
      full_q       <= 1'b0;
      temp_q       <= 1'b0;
      comp_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      prev_state_q <= prev_state_d;
      cnt_q        <= cnt_d;
      remaining_q  <= remaining_d;
      total_q      <= total_d;
      full_q       <= full_d;
      temp_q       <= temp_d;
      comp_q       <= comp_d;
      done_q       <= done_d;
    end
  end

  assign bus.sig_Full        = full_q;
  assign bus.sig_Temperature = temp_q;
  assign bus.sig_Completed   = comp_q;
  assign bus.phase_Done      = done_q;
  assign bus.remaining_Time  = remaining_q;
  assign bus.total_Ticks     = total_q;

endmodule

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer -- directed bench for phase_timer.
// Two instances share clock and reset: u_a with PRESCALE=1, u_b with
// PRESCALE=4. Observed outputs are packed as
// {sig_Full, sig_Temperature, sig_Completed, phase_Done, remaining_Time,
//  total_Ticks} and compared against hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_phase_timer;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  phase_timer_if #(.CNT_W(8)) a_if ();
  phase_timer_if #(.CNT_W(8)) b_if ();

  phase_timer #(.CNT_W(8), .PRESCALE(1)) u_a (
    .clock (clock),
    .reset (reset),
    .bus   (a_if)
  );

  phase_timer #(.CNT_W(8), .PRESCALE(4)) u_b (
    .clock (clock),
    .reset (reset),
    .bus   (b_if)
  );

  logic [27:0] a_obs;
  logic [27:0] b_obs;
  assign a_obs = {a_if.sig_Full, a_if.sig_Temperature, a_if.sig_Completed,
                  a_if.phase_Done, a_if.remaining_Time, a_if.total_Ticks};
  assign b_obs = {b_if.sig_Full, b_if.sig_Temperature, b_if.sig_Completed,
                  b_if.phase_Done, b_if.remaining_Time, b_if.total_Ticks};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    a_if.state = 3'd0;
    a_if.pause = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    if (a_obs !== 28'd0) begin
      $display("FAIL reset_a: got %h want %h", a_obs, 28'd0);
      n_bad++;
    end
    n_cmp++;
    if (b_obs !== 28'd0) begin
      $display("FAIL reset_b: got %h want %h", b_obs, 28'd0);
      n_bad++;
    end
    n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [27:0] exp_v [4];
    exp_v[0] = {4'b0000, 8'd2, 16'd0};
    exp_v[1] = {4'b0000, 8'd1, 16'd1};
    exp_v[2] = {4'b1001, 8'd0, 16'd2};
    exp_v[3] = {4'b1000, 8'd0, 16'd3};
    a_if.state = 3'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      if (a_obs !== exp_v[k]) begin
        $display("FAIL fill E%0d: got %h want %h", k + 1, a_obs, exp_v[k]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_to_idle();
    a_if.state = 3'd0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (a_obs !== 28'd0) begin
        $display("FAIL to_idle E%0d: got %h want %h", k + 1, a_obs, 28'd0);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_pause();
    logic [27:0] exp_v [10];
    exp_v[0] = {4'b0000, 8'd3, 16'd0};
    for (int k = 1; k < 6; k++) exp_v[k] = {4'b0000, 8'd3, 16'd0};
    exp_v[6] = {4'b0000, 8'd2, 16'd1};
    exp_v[7] = {4'b0000, 8'd1, 16'd2};
    exp_v[8] = {4'b0011, 8'd0, 16'd3};
    exp_v[9] = {4'b0010, 8'd0, 16'd4};
    go_idle();
    a_if.state = 3'd5;
    for (int k = 0; k < 10; k++) begin
      a_if.pause = (k >= 1 && k <= 5) ? 1'b1 : 1'b0;
      step();
      if (a_obs !== exp_v[k]) begin
        $display("FAIL pause E%0d: got %h want %h", k + 1, a_obs, exp_v[k]);
        n_bad++;
      end
      n_cmp++;
    end
    a_if.pause = 1'b0;
  endtask

  task automatic test_phase_change();
    logic [27:0] exp_v [8];
    exp_v[0] = {4'b0000, 8'd5, 16'd0};
    exp_v[1] = {4'b0000, 8'd4, 16'd1};
    exp_v[2] = {4'b0000, 8'd3, 16'd2};
    exp_v[3] = {4'b0000, 8'd3, 16'd2};
    exp_v[4] = {4'b0000, 8'd2, 16'd3};
    exp_v[5] = {4'b0000, 8'd1, 16'd4};
    exp_v[6] = {4'b0101, 8'd0, 16'd5};
    exp_v[7] = {4'b0100, 8'd0, 16'd6};
    go_idle();
    for (int k = 0; k < 8; k++) begin
      a_if.state = (k < 3) ? 3'd4 : 3'd3;
      step();
      if (a_obs !== exp_v[k]) begin
        $display("FAIL phase_change E%0d: got %h want %h", k + 1, a_obs, exp_v[k]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid_spin();
    logic [27:0] exp_v [8];
    exp_v[0] = {4'b0000, 8'd3, 16'd0};
    exp_v[1] = {4'b0000, 8'd2, 16'd1};
    exp_v[2] = {4'b0000, 8'd0, 16'd0};
    exp_v[3] = {4'b0000, 8'd3, 16'd0};
    exp_v[4] = {4'b0000, 8'd2, 16'd1};
    exp_v[5] = {4'b0000, 8'd1, 16'd2};
    exp_v[6] = {4'b0011, 8'd0, 16'd3};
    exp_v[7] = {4'b0010, 8'd0, 16'd4};
    go_idle();
    a_if.state = 3'd6;
    for (int k = 0; k < 8; k++) begin
      reset = (k == 2) ? 1'b1 : 1'b0;
      step();
      if (a_obs !== exp_v[k]) begin
        $display("FAIL reset_mid_spin E%0d: got %h want %h", k + 1, a_obs, exp_v[k]);
        n_bad++;
      end
      n_cmp++;
    end
    reset = 1'b0;
  endtask

  task automatic test_prescale();
    logic [27:0] exp_b;
    int          n;
    b_if.state = 3'd4;
    b_if.pause = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      n = (k - 1) / 4;
      exp_b = {2'b00, (n >= 5) ? 1'b1 : 1'b0, (k == 21) ? 1'b1 : 1'b0,
               8'(5 - n), 16'(n)};
      step();
      if (b_obs !== exp_b) begin
        $display("FAIL prescale E%0d: got %h want %h", k, b_obs, exp_b);
        n_bad++;
      end
      n_cmp++;
    end
    b_if.state = 3'd0;
    step();
    if (b_obs !== 28'd0) begin
      $display("FAIL prescale_idle: got %h want %h", b_obs, 28'd0);
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    a_if.state = 3'd0;
    a_if.pause = 1'b0;
    b_if.state = 3'd0;
    b_if.pause = 1'b0;
    test_reset();
    test_fill();
    test_to_idle();
    test_pause();
    test_phase_change();
    test_reset_mid_spin();
    test_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter CNT_W, default 8: width of the phase counter and of remaining_Time.
REQ-002 Parameter PRESCALE, default 1: clock cycles per timer tick; legal range 1..255.
REQ-003 Parameters FILL_TIME 2, HEAT_TIME 3, WASH_TIME 5, RINSE_TIME 3, SPIN_TIME 3: target duration of each phase in ticks; each SHALL be 1..2^CNT_W-1, checked at elaboration.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 state  input  3  controller state code: FILL_WATER=2, HEAT_WATER=3, WASH=4, RINSE=5, SPIN=6; any other code is untimed.
REQ-007 pause  input  1  high freezes all timing, for example while the door is open.
REQ-008 sig_Full  output  1  level; fill target reached in the current FILL_WATER phase.
REQ-009 sig_Temperature  output  1  level; heat target reached in the current HEAT_WATER phase.
REQ-010 sig_Completed  output  1  level; target reached in the current WASH, RINSE or SPIN phase.
REQ-011 phase_Done  output  1  one-cycle pulse in the cycle any of the three level flags rises.
REQ-012 remaining_Time  output  CNT_W  target minus count for timed states; 0 for untimed states.
REQ-013 total_Ticks  output  16  ticks since leaving an untimed state; saturates at 16'hFFFF.

Function
REQ-014 The block SHALL register prev_state. At an edge where state != prev_state, it SHALL:
  - load prev_state from state;
  - clear the phase counter, the prescaler and all three level flags.
REQ-015 At an edge where state == prev_state, state is timed and pause=0, the prescaler SHALL advance:
  - the tick is the cycle in which the prescaler equals PRESCALE-1;
  - on a tick the prescaler wraps to 0;
  - with PRESCALE=1 every such cycle is a tick.
REQ-016 On a tick the phase counter SHALL increment only while it is below the target of the current state. It SHALL hold at the target and never wrap.
REQ-017 The level flag for the current phase SHALL be set at the same edge where the counter becomes equal to the target. It SHALL stay set until the state changes or reset.
  - Latency: with PRESCALE=1, the flag is visible T+1 edges after the first edge that samples the new state, where T is the phase target.
REQ-018 phase_Done SHALL be high for exactly the one cycle after the edge that sets a level flag. It SHALL NOT re-assert while the flag is held.
REQ-019 pause=1 SHALL freeze the counter, prescaler and total_Ticks; the flags hold their values. A state change while paused still clears the timer per REQ-014.
REQ-020 remaining_Time SHALL be the registered value target minus counter, computed at CNT_W width; it is never negative.
REQ-021 total_Ticks SHALL increment on every tick. It SHALL clear at any edge where the sampled state is untimed.
REQ-022 A state change in the same cycle as a tick SHALL take the clear (REQ-014) and discard the tick.
REQ-023 A return to the same phase code after a different state SHALL restart that phase from 0.
REQ-024 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-025 While reset=1 at a rising edge, the block SHALL:
  - clear the counter, prescaler, total_Ticks and all flags;
  - clear phase_Done and remaining_Time;
  - set prev_state to 0.
REQ-026 Reset mid-phase SHALL abort that phase. After reset is released, a held timed state SHALL be treated as newly entered.

Structure
REQ-027 The state codes and the default phase durations SHALL live in the shared package wm_pkg, which the controller also uses.
REQ-028 One sub-module, tick_prescaler, SHALL provide the tick enable. It has clear, enable and PRESCALE ports; the phase counter stays inline.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  - Defaults; reset, then state=2 held: sig_Full rises 3 edges after the first sampling edge; phase_Done pulses for 1 cycle; remaining_Time steps 2,1,0.
  - PRESCALE=4, state=4 held: sig_Completed rises after 21 edges; total_Ticks=5 at that point.
  - state=5 with pause=1 for cycles 2..6: the completion flag is delayed by exactly 5 cycles; the counter holds across the pause.
  - state 4 -> 3 after 2 ticks: the counter restarts at 0; sig_Temperature rises 4 edges after the change; no flag from the WASH phase.
  - Reset asserted in the middle of SPIN: all outputs are 0 on the next edge; SPIN then restarts and completes after a full 3 ticks.
  - state moves to 0: total_Ticks=0 and remaining_Time=0 on the next edge.
